// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified instruction/data memory port.
package riscv_mem_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int DATA_W_DEF     = 32;
    localparam int MAX_STREAK_DEF = 4;

    // Which requester the read issued last cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, load/store port and RAM-side signals of the shared memory arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = riscv_mem_pkg::ADDR_W_DEF,
    parameter int DATA_W = riscv_mem_pkg::DATA_W_DEF
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_dout;

    // Core side: requesters plus the RAM's read data.
    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_din, mem_wren
    );

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_din, mem_wren
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between fetch and load/store; data wins unless
// fetch has already lost MAX_STREAK grants in a row.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int MAX_STREAK = MAX_STREAK_DEF
) (
    input logic              clock,
    input logic              clear,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    logic [SW-1:0] streak_q, streak_d;
    owner_e        owner_q, owner_d;
    logic          fetch_due;
    logic          f_gnt, d_gnt;

    always_comb begin
        fetch_due = bus.f_req && (!bus.d_req || streak_q == STREAK_MAX);
        f_gnt     = !clear && fetch_due;
        d_gnt     = !clear && bus.d_req && !fetch_due;
    end

    always_comb begin
        streak_d = streak_q;
        if (f_gnt || !bus.f_req)
            streak_d = '0;
        else if (d_gnt && streak_q != STREAK_MAX)
            streak_d = streak_q + 1'b1;
    end

    // Stores never produce a response, so they leave owner at NONE.
    always_comb begin
        owner_d = OWN_NONE;
        if (f_gnt)
            owner_d = OWN_F;
        else if (d_gnt && !bus.d_we)
            owner_d = OWN_D;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            streak_q <= '0;
            owner_q  <= OWN_NONE;
        end else begin
            streak_q <= streak_d;
            owner_q  <= owner_d;
        end
    end

    always_comb begin
        bus.f_gnt    = f_gnt;
        bus.d_gnt    = d_gnt;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        bus.mem_wren = 1'b0;
        if (f_gnt) begin
            bus.mem_addr = bus.f_addr;
        end else if (d_gnt) begin
            bus.mem_addr = bus.d_addr;
            bus.mem_din  = bus.d_wdata;
            bus.mem_wren = bus.d_we;
        end
    end

    always_comb begin
        bus.f_rvalid = (owner_q == OWN_F);
        bus.d_rvalid = (owner_q == OWN_D);
        bus.f_rdata  = bus.f_rvalid ? bus.mem_dout : '0;
        bus.d_rdata  = bus.d_rvalid ? bus.mem_dout : '0;
    end

endmodule
